// File: rtl/rv32i_intc.sv
// Parametrised interrupt controller: per-source edge/level latching, enable mask,
// fixed priority (source 0 highest) and claim/complete over a 16-bit register port.
module rv32i_intc #(
    parameter int unsigned NUM_SRC  = 5,
    parameter int unsigned PORT_LEN = 16,
    parameter int unsigned ID_BITS  = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_SRC-1:0]  src_i,
    input  logic [1:0]          addr_i,
    input  logic [PORT_LEN-1:0] data_i,
    input  logic                write_i,
    input  logic                read_i,
    output logic [PORT_LEN-1:0] data_o,
    output logic                irq_o,
    output logic [ID_BITS-1:0]  irq_id_o,
    output logic                active_o
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  enable_q, enable_d;
    logic [NUM_SRC-1:0]  mode_q, mode_d;
    logic [NUM_SRC-1:0]  src_q;
    logic                in_service_q, in_service_d;
    logic [ID_BITS-1:0]  active_id_q, active_id_d;
    logic [PORT_LEN-1:0] data_q, data_d;
    logic                armed_q;

    logic [NUM_SRC-1:0]  cand_c;
    logic [ID_BITS-1:0]  cand_id_c;
    logic                claim_c;
    logic                complete_c;
    logic [NUM_SRC-1:0]  rise_c;
    logic [NUM_SRC-1:0]  w1c_c;
    logic [NUM_SRC-1:0]  claim_clr_c;
    logic [PORT_LEN-1:0] claim_word_c;
    logic                unused_data;

    // Upper data bits carry no register state; kept only to reference the full bus.
    assign unused_data = ^data_i;

    assign cand_c = pending_q & enable_q;

    // Lowest-index candidate wins; scan downward so the last hit is the smallest index.
    always_comb begin
        cand_id_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (cand_c[i]) cand_id_c = ID_BITS'(i);
        end
    end

    assign claim_c    = read_i && !write_i && (addr_i == ADDR_CLAIM) && !in_service_q && (|cand_c);
    assign complete_c = write_i && (addr_i == ADDR_CLAIM) && in_service_q
                        && (data_i[ID_BITS-1:0] == active_id_q);

    // Edge detection is held off for the first cycle after reset so sources already high do not fire.
    assign rise_c = armed_q ? (src_i & ~src_q) : '0;
    assign w1c_c  = (write_i && addr_i == ADDR_PENDING) ? (data_i[NUM_SRC-1:0] & ~mode_q) : '0;

    always_comb begin
        claim_clr_c = '0;
        if (claim_c) claim_clr_c[cand_id_c] = ~mode_q[cand_id_c];
    end

    always_comb begin
        claim_word_c                 = '0;
        claim_word_c[PORT_LEN-1]     = 1'b1;
        claim_word_c[ID_BITS-1:0]    = cand_id_c;
    end

    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        in_service_d = in_service_q;
        active_id_d  = active_id_q;
        data_d       = data_q;

        // Per bit: level sources track the input; edge sources set-wins over W1C/claim clears.
        pending_d = (mode_q & src_i)
                  | (~mode_q & ((pending_q & ~w1c_c & ~claim_clr_c) | rise_c));

        if (write_i) begin
            case (addr_i)
                ADDR_ENABLE: enable_d = data_i[NUM_SRC-1:0];
                ADDR_MODE:   mode_d   = data_i[NUM_SRC-1:0];
                default:     ;
            endcase
        end

        if (complete_c) in_service_d = 1'b0;

        if (read_i) begin
            case (addr_i)
                ADDR_PENDING: data_d = PORT_LEN'(pending_q);
                ADDR_ENABLE:  data_d = PORT_LEN'(enable_q);
                ADDR_MODE:    data_d = PORT_LEN'(mode_q);
                default:      data_d = claim_c ? claim_word_c : '0;
            endcase
        end

        if (claim_c) begin
            in_service_d = 1'b1;
            active_id_d  = cand_id_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            src_q        <= '0;
            in_service_q <= 1'b0;
            active_id_q  <= '0;
            data_q       <= '0;
            armed_q      <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            src_q        <= src_i;
            in_service_q <= in_service_d;
            active_id_q  <= active_id_d;
            data_q       <= data_d;
            armed_q      <= 1'b1;
        end
    end

    assign data_o   = data_q;
    assign irq_o    = !in_service_q && (|cand_c);
    assign irq_id_o = cand_id_c;
    assign active_o = in_service_q;

endmodule
